bsg_bus_initiator: RTL
======================

Name: bsg_bus_initiator

Overview:
- Initiator (master) end of the BSG register valid/ready bus. The register-file responder sits at the far end: BSG_CONTROL at 0x10, DATA1 at 0x11, DATA2 at 0x12.
- Queues host read/write requests in a small FIFO and issues them one at a time on the bus.
- Returns one response per request: read data or write acknowledge, plus a timeout error flag.
- Sits between the host/CPU-side command source and the BSG register responder.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of two, >=2)
- TIMEOUT, 16, maximum bus_valid cycles without bus_ready before abort (>=2)
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  request queue can accept
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target register address
- req_wdata  in  DATA_W  write data (ignored for reads)
- bus_valid  out  1  transaction presented to responder
- bus_write  out  1  transaction direction
- bus_addr  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  transaction write data
- bus_ready  in  1  responder accepts/completes the transaction
- bus_rdata  in  DATA_W  responder read data, valid with bus_ready on reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  captured read data; 0 for writes and errors
- rsp_err  out  1  1 = transaction timed out
- busy  out  1  FIFO non-empty or transaction in flight

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, except req_ready=1.
  - FIFO emptied; state IDLE; timeout counter 0.
  - Reset mid-transaction drops bus_valid immediately. The in-flight request and queued requests are discarded and no response is produced.
- Request FIFO:
  - req_ready = !full, from registered occupancy.
  - Push on clock edge with req_valid && req_ready, storing {write, addr, wdata}.
  - Push and pop on the same edge are legal; occupancy is unchanged.
  - When full, req_ready=0 and req_valid is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM, two states:
  - IDLE, FIFO non-empty at an edge: pop head into the bus registers; bus_valid=1 after that edge; counter cleared; go ISSUE.
  - IDLE, FIFO empty: bus outputs hold, bus_valid=0.
  - ISSUE: bus_valid, bus_write, bus_addr and bus_wdata are held stable until the transaction ends.
  - ISSUE, edge with bus_ready=1: normal completion.
    - bus_valid=0 after the edge.
    - rsp_valid=1 for exactly one cycle.
    - rsp_rdata = bus_rdata sampled at that edge for reads, 0 for writes; rsp_err=0.
    - Go IDLE.
  - ISSUE, edge with bus_ready=0: counter increments.
    - If the counter equals TIMEOUT-1 at that edge, abort: bus_valid=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; go IDLE.
    - bus_valid is therefore high for exactly TIMEOUT cycles on a timeout.
  - bus_ready=1 on the edge that would time out: completion wins and rsp_err=0.
- bus_ready while bus_valid=0 is ignored.
- Latency:
  - Request accepted at edge N into an empty FIFO with FSM in IDLE: bus_valid rises after edge N+1.
  - rsp_valid is asserted in the cycle after the completion edge.
  - Back-to-back queued requests: one bus_valid-low cycle between transactions.
- Responses are in request order; one response per accepted request. No response backpressure: rsp_valid is a pulse.
- busy = (occupancy != 0) || state==ISSUE.

Test Plan:
- Reset, then write addr 0x10 data 0x05 with bus_ready tied 1 -> bus_valid high one cycle with bus_write=1, bus_addr=0x10, bus_wdata=0x05; rsp_valid pulse, rsp_err=0, rsp_rdata=0x00.
- Read 0x11; responder returns bus_rdata=0xA5 with bus_ready after 3 wait cycles -> bus_valid high 4 cycles, signals stable; rsp_rdata=0xA5, rsp_err=0.
- Push 5 requests with bus_ready=0 -> req_ready drops after the 4th queued entry (1 in flight + 4 queued). Then raise bus_ready=1 -> all 5 complete in order, one idle cycle between each, busy falls after the last.
- Read 0x12 with bus_ready held 0 -> bus_valid high exactly 16 cycles; rsp_valid with rsp_err=1, rsp_rdata=0. The next queued request then issues normally.
- bus_ready=1 on the 16th bus_valid cycle -> normal completion, rsp_err=0.
- Assert rst_n=0 mid-ISSUE with 2 requests queued -> bus_valid=0 asynchronously, no rsp_valid; after release busy=0, req_ready=1, no stale transactions issued.

Source files
------------

// File: rtl/bsg_bus_initiator.sv
// Initiator end of the BSG register valid/ready bus. Host requests are queued
// in a small FIFO and issued one at a time. Each request gets exactly one response.
module bsg_bus_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              bus_valid,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic {IDLE, ISSUE} state_e;

  req_t              mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  state_e            state_q;
  logic [CW-1:0]     tmo_q;
  req_t              bus_q;
  logic              bus_valid_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              push, pop;

  assign req_ready = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_write, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            bus_q       <= mem_q[rptr_q];
            bus_valid_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Completion is checked first so a ready on the last cycle still wins.
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= bus_q.write ? '0 : bus_rdata;
            state_q     <= IDLE;
          end else if (tmo_q == CW'(TIMEOUT-1)) begin
            bus_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_write = bus_q.write;
  assign bus_addr  = bus_q.addr;
  assign bus_wdata = bus_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (cnt_q != '0) || (state_q == ISSUE);

endmodule
